// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - lamp codes, monitor state encoding and fault-code bit positions
// Purpose: shared definitions for signal_conflict_monitor and tl_conflict_check.
// Ports: none (package).
package tl_pkg;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [1:0] {
      MONITOR = 2'd0,
      PENDING = 2'd1,
      FAULT   = 2'd2,
      RECOVER = 2'd3
   } mon_state_e;

   // Bit positions inside the violation vector / fault_code
   localparam int FC_S   = 0;
   localparam int FC_MT  = 1;
   localparam int FC_INV = 2;

   // Counters only ever hold 0..limit-1, so $clog2(limit) bits suffice (at least one bit)
   function automatic int cnt_width(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

   function automatic logic is_onehot(input logic [2:0] c);
      return (c == LAMP_RED) || (c == LAMP_YEL) || (c == LAMP_GRN);
   endfunction

endpackage

// File: rtl/tl_conflict_check.sv
// rtl/tl_conflict_check.sv - combinational conflict / invalid-code detector for four light codes
// Purpose: flags aspects that must never reach the lamps.
// Ports:
//   light_M1, light_M2, light_MT, light_S  in  3  controller codes {R,Y,G}
//   v                                      out 3  [0]=S conflict, [1]=MT/M2 conflict, [2]=invalid code
module tl_conflict_check
   import tl_pkg::*;
(
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_S,
   output logic [2:0] v
);

   always_comb begin
      v = '0;
      v[FC_INV] = !(is_onehot(light_M1) && is_onehot(light_M2) &&
                    is_onehot(light_MT) && is_onehot(light_S));
      // Side road may only show a non-red aspect when every main-road head is red
      v[FC_S]   = (light_S != LAMP_RED) &&
                  ((light_M1 != LAMP_RED) || (light_M2 != LAMP_RED) || (light_MT != LAMP_RED));
      // Turn movement crosses opposing main road M2
      v[FC_MT]  = (light_MT != LAMP_RED) && (light_M2 != LAMP_RED);
   end

endmodule

// File: rtl/signal_conflict_monitor.sv
// rtl/signal_conflict_monitor.sv - safety stage between phase controller and lamp drivers
// Purpose: registers the four light codes to the lamps, forces all-red on any conflict,
//   latches persistent violations into a flashing-red FAULT released only by operator clear.
// Optional feature: FAULT_LOG_EN builds the fault_code / fault_cnt log registers.
// Ports:
//   clk                                 in   1      clock, posedge
//   rst                                 in   1      synchronous active-low reset
//   light_M1/M2/MT/S                    in   3      controller codes
//   clear_fault                         in   1      operator clear, level-sampled
//   lamp_M1/M2/MT/S                     out  3      lamp drive (000 = dark)
//   fault                               out  1      high in FAULT
//   fault_code                          out  3      violation vector latched at FAULT entry
//   fault_cnt                           out  CNT_W  saturating FAULT entry count
module signal_conflict_monitor
   import tl_pkg::*;
#(
   parameter int FAULT_CYCLES  = 2,
   parameter int FLASH_HALF    = 4,
   parameter int ALLRED_CYCLES = 3,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light_M1,
   input  logic [2:0]       light_M2,
   input  logic [2:0]       light_MT,
   input  logic [2:0]       light_S,
   input  logic             clear_fault,
   output logic [2:0]       lamp_M1,
   output logic [2:0]       lamp_M2,
   output logic [2:0]       lamp_MT,
   output logic [2:0]       lamp_S,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] fault_cnt
);

   localparam int PC_W = cnt_width(FAULT_CYCLES);
   localparam int FL_W = cnt_width(FLASH_HALF);
   localparam int AR_W = cnt_width(ALLRED_CYCLES);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(FAULT_CYCLES - 1);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);
   localparam logic [AR_W-1:0] AR_LAST = AR_W'(ALLRED_CYCLES - 1);
   localparam logic [11:0]     ALL_RED = {4{LAMP_RED}};
   localparam logic [11:0]     ALL_OFF = {4{LAMP_OFF}};

   mon_state_e      state_q, state_d;
   logic [PC_W-1:0] pcnt_q, pcnt_d;
   logic [FL_W-1:0] flash_q, flash_d;
   logic            dark_q, dark_d;     // flash phase: 0 = red half, 1 = dark half
   logic [AR_W-1:0] ar_q, ar_d;
   logic [11:0]     lamp_q, lamp_d;
   logic [11:0]     lights;
   logic [2:0]      v;
   logic            v_any;
   logic            enter_fault;

   assign lights = {light_M1, light_M2, light_MT, light_S};
   assign v_any  = |v;

   tl_conflict_check u_check (
      .light_M1 (light_M1),
      .light_M2 (light_M2),
      .light_MT (light_MT),
      .light_S  (light_S),
      .v        (v)
   );

   always_comb begin
      state_d     = state_q;
      pcnt_d      = pcnt_q;
      flash_d     = flash_q;
      dark_d      = dark_q;
      ar_d        = ar_q;
      lamp_d      = ALL_RED;
      enter_fault = 1'b0;

      unique case (state_q)
         MONITOR: begin
            if (!v_any)                 lamp_d = lights;
            else if (FAULT_CYCLES == 1) enter_fault = 1'b1;
            else                        state_d = PENDING;
         end
         PENDING: begin
            if (!v_any)                 state_d = MONITOR;
            else if (pcnt_q == PC_LAST) enter_fault = 1'b1;
            else                        pcnt_d = pcnt_q + 1'b1;
         end
         FAULT: begin
            if (clear_fault && !v_any) begin
               state_d = RECOVER;
            end else begin
               if (flash_q == FL_LAST) begin
                  flash_d = '0;
                  dark_d  = ~dark_q;
               end else begin
                  flash_d = flash_q + 1'b1;
               end
               lamp_d = dark_d ? ALL_OFF : ALL_RED;
            end
         end
         RECOVER: begin
            if (v_any) begin
               enter_fault = 1'b1;
            end else if (ar_q == AR_LAST) begin
               // All-red hold complete: this edge already behaves as MONITOR
               state_d = MONITOR;
               lamp_d  = lights;
            end else begin
               ar_d = ar_q + 1'b1;
            end
         end
         default: state_d = MONITOR;
      endcase

      if (enter_fault) state_d = FAULT;

      // Every state change restarts all counters; PENDING entry already counts one violating cycle
      if (state_d != state_q) begin
         pcnt_d  = (state_d == PENDING) ? PC_W'(1) : '0;
         flash_d = '0;
         dark_d  = 1'b0;
         ar_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= MONITOR;
         pcnt_q  <= '0;
         flash_q <= '0;
         dark_q  <= 1'b0;
         ar_q    <= '0;
         lamp_q  <= ALL_RED;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         flash_q <= flash_d;
         dark_q  <= dark_d;
         ar_q    <= ar_d;
         lamp_q  <= lamp_d;
      end
   end

   assign {lamp_M1, lamp_M2, lamp_MT, lamp_S} = lamp_q;
   assign fault = (state_q == FAULT);

`ifdef FAULT_LOG_EN
   logic [2:0]       code_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         code_q <= '0;
         cnt_q  <= '0;
      end else if (enter_fault) begin
         code_q <= v;
         if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign fault_code = code_q;
   assign fault_cnt  = cnt_q;
`else
   assign fault_code = '0;
   assign fault_cnt  = '0;
`endif

endmodule
